fetch_unit: RTL and testbench

Instruction fetch stage of the CPU datapath. Holds the program counter, issues word reads to instruction memory over a req/ack handshake, and buffers up to two fetched instructions for decode through a valid/ready interface. Decode extracts the 16-bit immediate, which the sign-extension stage widens to 32 bits. That sign-extended offset comes back here as `branch_simm` to redirect the PC on a taken branch.

---
 rtl/fetch_unit.sv | 70 +++++++
 tb/tb_fetch_unit.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: program counter, single-outstanding imem read, and 2-entry instruction buffer for decode
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    input  logic        branch_en,
    input  logic [31:0] branch_simm
);
    typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;
    state_t state, state_nx;
    logic [31:0] pc, pc_nx, addr_nx, base;
    logic [63:0] e0, e1, e0_nx, e1_nx, s0, s1;
    logic [1:0] cnt, cnt_nx, mid;
    logic xfer, accept, br, pop, push, hold, discard_nx, issue;

    assign imem_req    = state != IDLE;
    assign instr_valid = cnt != 2'd0;
    assign instr_pc    = e0[63:32];
    assign instr       = e0[31:0];

    // Entries shift toward the head on pop and are zeroed when vacated, so an empty head reads as 0.
    always_comb begin
        xfer       = imem_req && imem_ack;
        accept     = instr_valid && instr_ready;
        br         = accept && branch_en;
        pop        = accept && !branch_en;
        push       = xfer && state == FETCH && !br;
        mid        = cnt - {1'b0, pop};
        s0         = pop ? e1 : e0;
        s1         = pop ? 64'd0 : e1;
        e0_nx      = br ? 64'd0 : (push && mid == 2'd0) ? {imem_addr, imem_rdata} : s0;
        e1_nx      = br ? 64'd0 : (push && mid == 2'd1) ? {imem_addr, imem_rdata} : s1;
        cnt_nx     = br ? 2'd0 : mid + {1'b0, push};
        hold       = imem_req && !xfer;
        discard_nx = br ? hold : (state == FLUSH && !xfer);
        base       = br ? instr_pc + 32'd4 + (branch_simm << 2) : pc;
        issue      = !hold && cnt_nx != 2'd2 && !discard_nx;
        pc_nx      = issue ? base + 32'd4 : base;
        addr_nx    = issue ? base : imem_addr;
        state_nx   = issue ? FETCH : !hold ? IDLE : discard_nx ? FLUSH : FETCH;
    end

    // State, PC, outstanding request address and buffer entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            e0        <= 64'd0;
            e1        <= 64'd0;
            cnt       <= 2'd0;
        end else begin
            state     <= state_nx;
            pc        <= pc_nx;
            imem_addr <= addr_nx;
            e0        <= e0_nx;
            e1        <= e1_nx;
            cnt       <= cnt_nx;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'd0;
    logic        instr_ready = 1'b0;
    logic        branch_en = 1'b0;
    logic [31:0] branch_simm = 32'd0;
    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, instr_pc;
    logic        w_req, w_valid;
    logic [31:0] w_addr, w_instr, w_pc;

    int tests = 0;
    int fails = 0;

    logic [63:0] m_q[$];
    bit          m_out, m_drop;
    logic [31:0] m_pc, m_addr;

    fetch_unit #(.RESET_PC(32'h0000_0100)) u0 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
        .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready),
        .branch_en(branch_en), .branch_simm(branch_simm)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u1 (
        .clk(clk), .rst_n(rst_n), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instr_valid(w_valid),
        .instr(w_instr), .instr_pc(w_pc), .instr_ready(instr_ready),
        .branch_en(branch_en), .branch_simm(branch_simm)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_out  = 0;
        m_drop = 0;
        m_pc   = 32'h100;
        m_addr = 32'h100;
    endtask

    task automatic check_all();
        logic [63:0] hd;
        hd = (m_q.size() != 0) ? m_q[0] : 64'd0;
        check("req", {31'd0, imem_req}, {31'd0, m_out});
        check("addr", imem_addr, m_addr);
        check("valid", {31'd0, instr_valid}, {31'd0, m_q.size() != 0});
        check("instr", instr, hd[31:0]);
        check("instr_pc", instr_pc, hd[63:32]);
    endtask

    task automatic step(input logic a, input logic r, input logic b, input logic [31:0] s);
        logic xf, ac, tk;
        logic [31:0] hp;
        imem_ack    = a;
        instr_ready = r;
        branch_en   = b;
        branch_simm = s;
        imem_rdata  = $urandom;
        @(posedge clk);
        if (rst_n) begin
            xf = m_out && a;
            ac = m_q.size() != 0 && r;
            tk = ac && b;
            hp = ac ? m_q[0][63:32] : 32'd0;
            if (ac) void'(m_q.pop_front());
            if (tk) m_q.delete();
            else if (xf && !m_drop) m_q.push_back({m_addr, imem_rdata});
            if (tk) m_pc = hp + 32'd4 + (s << 2);
            m_drop = tk ? (m_out && !xf) : (m_drop && !xf);
            if (xf) m_out = 0;
            if (!m_out && m_q.size() < 2 && !m_drop) begin
                m_out  = 1;
                m_addr = m_pc;
                m_pc   = m_pc + 32'd4;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        logic [31:0] wrap_exp [3];
        logic [31:0] hp, s200;
        int budget;
        wrap_exp[0] = 32'hFFFF_FFF8;
        wrap_exp[1] = 32'hFFFF_FFFC;
        wrap_exp[2] = 32'h0000_0000;
        model_reset();
        @(negedge clk);
        check_all();
        check("rst_pc_wrap", w_addr, 32'hFFFF_FFF8);
        rst_n = 1'b1;
        // Zero-wait stream from both instances, wrap checked on the second one.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            if (i < 3) check("wrap_addr", w_addr, wrap_exp[i]);
        end
        // Reset while a request awaits its ack; acks during reset are ignored.
        step(1'b0, 1'b1, 1'b0, 32'd0);
        check("req_pending", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        step(1'b1, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        rst_n = 1'b1;
        // Backpressure: buffer fills with 0x100, 0x104 and requesting stops.
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 32'd0);
        check("bp_head", instr_pc, 32'h100);
        check("bp_req", {31'd0, imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 1'b0, 32'd0);
        // Branch coincident with a transfer.
        hp = instr_pc;
        step(1'b1, 1'b1, 1'b1, 32'h10);
        check("coin_addr", imem_addr, hp + 32'h44);
        check("coin_valid", {31'd0, instr_valid}, 32'd0);
        // Redirect to 0x200, then branch back while the next fetch is in flight.
        budget = 10;
        while (m_q.size() == 0 && budget > 0) begin
            step(1'b1, 1'b1, 1'b0, 32'd0);
            budget--;
        end
        check("wait_budget", {31'd0, m_q.size() != 0}, 32'd1);
        s200 = (32'h200 - m_q[0][63:32] - 32'd4) >> 2;
        step(1'b1, 1'b1, 1'b1, s200);
        check("to_200", imem_addr, 32'h200);
        step(1'b1, 1'b0, 1'b0, 32'd0);
        check("head_200", instr_pc, 32'h200);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC);
        check("flush_valid", {31'd0, instr_valid}, 32'd0);
        check("flush_addr", imem_addr, 32'h204);
        step(1'b0, 1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("tgt_addr", imem_addr, 32'h1F4);
        check("tgt_empty", {31'd0, instr_valid}, 32'd0);
        step(1'b1, 1'b1, 1'b0, 32'd0);
        check("tgt_pc", instr_pc, 32'h1F4);
        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 6, $urandom_range(0, 9) < 7,
                 $urandom_range(0, 9) < 2, $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 15) - 8);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
